// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file writeback arbiter.
// Imported by the arbiter top and its interface.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two valid/ready requesters plus the register-file write port.
// master = writeback stage / register file side, slave = the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
);

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;

  logic              rf_write_en;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic              init_done;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_write_en, rf_write_addr, rf_write_data, init_done
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_write_en, rf_write_addr, rf_write_data, init_done
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. The pointer selects the winner on contention;
// the caller registers next_ptr.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       next_ptr
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant    = 2'b00;
    next_ptr = ptr;
    if (req[0] && (!req[1] || !ptr)) begin
      grant    = 2'b01;
      next_ptr = 1'b1;
    end else if (req[1]) begin
      grant    = 2'b10;
      next_ptr = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: zeroes x1..x(NUM_REGS-1) after reset,
// then round-robins ALU (req0) and load (req1) writebacks onto the port.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REGS  = regfile_pkg::NUM_REGS,
  parameter int ADDR_W    = regfile_pkg::ADDR_W,
  parameter int DATA_W    = regfile_pkg::DATA_W,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  localparam state_t            RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;
  localparam logic [ADDR_W-1:0] LAST_REG    = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic              ptr_q, ptr_d;
  logic              init_done_q;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic       run_active;
  logic       zero0, zero1;
  logic [1:0] arb_req, grant;

  // State register plus the datapath registers that follow it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      cnt_q       <= ADDR_W'(1);
      ptr_q       <= 1'b0;
      init_done_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_q | (state_q == ST_RUN);
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      if (state_q == ST_INIT) cnt_q <= cnt_q + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && cnt_q == LAST_REG) state_d = ST_RUN;
  end

  // Handshakes open only once init_done is visible, so no ready overlaps the sweep.
  assign run_active = (state_q == ST_RUN) && init_done_q;
  assign zero0      = (bus.req0_addr == ADDR_W'(REG_ZERO));
  assign zero1      = (bus.req1_addr == ADDR_W'(REG_ZERO));
  assign arb_req    = {run_active & bus.req1_valid & ~zero1,
                       run_active & bus.req0_valid & ~zero0};

  rr_arbiter2 u_arb (
    .req      (arb_req),
    .ptr      (ptr_q),
    .grant    (grant),
    .next_ptr (ptr_d)
  );

  always_comb begin
    bus.req0_ready = run_active & bus.req0_valid & (zero0 | grant[0]);
    bus.req1_ready = run_active & bus.req1_valid & (zero1 | grant[1]);
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (state_q == ST_INIT) begin
      wr_en_d   = 1'b1;
      wr_addr_d = cnt_q;
      wr_data_d = '0;
    end else if (grant[0]) begin
      wr_en_d   = 1'b1;
      wr_addr_d = bus.req0_addr;
      wr_data_d = bus.req0_data;
    end else if (grant[1]) begin
      wr_en_d   = 1'b1;
      wr_addr_d = bus.req1_addr;
      wr_data_d = bus.req1_data;
    end
  end

  assign bus.rf_write_en   = wr_en_q;
  assign bus.rf_write_addr = wr_addr_q;
  assign bus.rf_write_data = wr_data_q;
  assign bus.init_done     = init_done_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: sweep, handshakes, round-robin,
// x0 bypass, same-address collision, async reset, and the INIT_ZERO=0 variant.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] rf_mem [32];

  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter_if bus_nz ();

  regfile_wb_arbiter #(.INIT_ZERO(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  regfile_wb_arbiter #(.INIT_ZERO(1'b0)) dut_nz (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nz)
  );

  always #5 clk = ~clk;

  // Register file seen by the write port.
  always @(posedge clk) begin
    if (bus.rf_write_en) rf_mem[bus.rf_write_addr] <= bus.rf_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input logic en, input logic [4:0] addr,
                            input logic [31:0] data);
    check({tag, ".en"},   32'(bus.rf_write_en),   32'(en));
    check({tag, ".addr"}, 32'(bus.rf_write_addr), 32'(addr));
    check({tag, ".data"}, bus.rf_write_data,      data);
  endtask

  task automatic check_sweep(input string tag);
    for (int i = 1; i <= 31; i++) begin
      tick();
      check_port($sformatf("%s[%0d]", tag, i), 1'b1, 5'(i), 32'h0);
      check($sformatf("%s[%0d].rdy0", tag, i), 32'(bus.req0_ready), 32'h0);
      check($sformatf("%s[%0d].rdy1", tag, i), 32'(bus.req1_ready), 32'h0);
      check($sformatf("%s[%0d].done", tag, i), 32'(bus.init_done),  32'h0);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.req0_valid  = 1'b1;
    bus.req0_addr   = 5'd3;
    bus.req0_data   = 32'hA;
    bus.req1_valid  = 1'b1;
    bus.req1_addr   = 5'd4;
    bus.req1_data   = 32'hB;
    bus_nz.req0_valid = 1'b0;
    bus_nz.req0_addr  = 5'd0;
    bus_nz.req0_data  = 32'h0;
    bus_nz.req1_valid = 1'b0;
    bus_nz.req1_addr  = 5'd0;
    bus_nz.req1_data  = 32'h0;

    #12;
    check_port("reset", 1'b0, 5'd0, 32'h0);
    check("reset.done",    32'(bus.init_done),    32'h0);
    check("reset.rdy0",    32'(bus.req0_ready),   32'h0);
    check("reset.nz_done", 32'(bus_nz.init_done), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Sweep with both valids high; readys must stay low throughout.
    tick();
    check("nz.done_first_cycle", 32'(bus_nz.init_done),   32'h1);
    check("nz.no_write",         32'(bus_nz.rf_write_en), 32'h0);
    check_port("sweep[1]", 1'b1, 5'd1, 32'h0);
    check("sweep[1].rdy0", 32'(bus.req0_ready), 32'h0);
    for (int i = 2; i <= 31; i++) begin
      tick();
      check_port($sformatf("sweep[%0d]", i), 1'b1, 5'(i), 32'h0);
      check($sformatf("sweep[%0d].rdy0", i), 32'(bus.req0_ready), 32'h0);
      check($sformatf("sweep[%0d].rdy1", i), 32'(bus.req1_ready), 32'h0);
      check($sformatf("sweep[%0d].done", i), 32'(bus.init_done),  32'h0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    check("sweep.done_rise", 32'(bus.init_done),   32'h1);
    check("sweep.en_drop",   32'(bus.rf_write_en), 32'h0);
    check("sweep.x1_zero",   rf_mem[1],  32'h0);
    check("sweep.x31_zero",  rf_mem[31], 32'h0);

    // Single ALU writeback; pointer moves to 1.
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd5;
    bus.req0_data  = 32'hDEADBEEF;
    #1;
    check("single.rdy0", 32'(bus.req0_ready), 32'h1);
    check("single.rdy1", 32'(bus.req1_ready), 32'h0);
    tick();
    bus.req0_valid = 1'b0;
    check_port("single.write", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check_port("single.idle", 1'b0, 5'd5, 32'hDEADBEEF);

    // x0 request bypasses arbitration; req1 wins the port and pointer returns to 0.
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd0;
    bus.req0_data  = 32'h55;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 5'd7;
    bus.req1_data  = 32'h77;
    #1;
    check("x0.rdy0", 32'(bus.req0_ready), 32'h1);
    check("x0.rdy1", 32'(bus.req1_ready), 32'h1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check_port("x0.write7", 1'b1, 5'd7, 32'h77);
    tick();
    check("x0.idle", 32'(bus.rf_write_en), 32'h0);
    bus.req0_valid = 1'b1;
    #1;
    check("x0only.rdy0", 32'(bus.req0_ready), 32'h1);
    tick();
    bus.req0_valid = 1'b0;
    check_port("x0only.nowrite", 1'b0, 5'd7, 32'h77);

    // Continuous contention from pointer 0: grants alternate req0, req1, ...
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd3;
    bus.req0_data  = 32'hA;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 5'd4;
    bus.req1_data  = 32'hB;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr[%0d].rdy0", k), 32'(bus.req0_ready), (k % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("rr[%0d].rdy1", k), 32'(bus.req1_ready), (k % 2 == 1) ? 32'h1 : 32'h0);
      tick();
      check_port($sformatf("rr[%0d]", k), 1'b1, (k % 2 == 0) ? 5'd3 : 5'd4,
                 (k % 2 == 0) ? 32'hA : 32'hB);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    check("rr.idle", 32'(bus.rf_write_en), 32'h0);

    // Same-address collision on x9: req0 first, req1 last and wins.
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd9;
    bus.req0_data  = 32'h1;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 5'd9;
    bus.req1_data  = 32'h2;
    #1;
    check("coll.rdy0", 32'(bus.req0_ready), 32'h1);
    check("coll.rdy1", 32'(bus.req1_ready), 32'h0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    check("coll.rdy1_next", 32'(bus.req1_ready), 32'h1);
    check_port("coll.first", 1'b1, 5'd9, 32'h1);
    tick();
    bus.req1_valid = 1'b0;
    check_port("coll.second", 1'b1, 5'd9, 32'h2);
    tick();
    check("coll.x9", rf_mem[9], 32'h2);
    check("coll.idle", 32'(bus.rf_write_en), 32'h0);

    // Reset from RUN, then an asynchronous reset in the middle of the sweep.
    rst_n = 1'b0;
    #1;
    check("rst_run.done", 32'(bus.init_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) tick();
    check_port("mid.addr10", 1'b1, 5'd10, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_port("mid.async_clear", 1'b0, 5'd0, 32'h0);
    check("mid.async_done", 32'(bus.init_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_sweep("resweep");
    tick();
    check("resweep.done_rise", 32'(bus.init_done),   32'h1);
    check("resweep.en_drop",   32'(bus.rf_write_en), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
